// File: rtl/fetch_decode_buffer.sv
// Two-entry elastic buffer between fetch and decode. It holds {instr, pc_next}
// pairs, stops accepting fetches after a HALT, and drops everything on flush.
module fetch_decode_buffer #(
  parameter logic [15:0] NOP_WORD = 16'h0800,
  parameter logic [4:0]  HALT_OPC = 5'b00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [15:0] if_instr,
  input  logic [15:0] if_pc_next,
  output logic        if_ready,
  output logic        id_valid,
  output logic [15:0] id_instr,
  output logic [15:0] id_pc_next,
  input  logic        id_ready,
  input  logic        flush,
  output logic        halted,
  output logic [1:0]  count
);

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc_next;
  } entry_t;

  localparam logic [1:0] COUNT_FULL = 2'd2;

  entry_t     mem_q [2];
  entry_t     head;
  logic [1:0] count_q, count_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic       halted_q, halted_d;
  logic       push, pop;

  // if_ready depends only on state, so fetch never sees a combinational loop
  // through the decode handshake.
  assign if_ready = (count_q != COUNT_FULL) && !halted_q;
  assign id_valid = (count_q != 2'd0);

  assign push = if_valid && if_ready && !flush;
  assign pop  = id_valid && id_ready && !flush;

  assign head       = mem_q[rd_ptr_q];
  assign id_instr   = id_valid ? head.instr   : NOP_WORD;
  assign id_pc_next = id_valid ? head.pc_next : 16'h0000;
  assign halted     = halted_q;
  assign count      = count_q;

  // NOTE: every signal written here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    halted_d = halted_q;
    if (flush) begin
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      halted_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      unique case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
      // The HALT itself is stored and delivered; only later fetches are refused.
      if (push && (if_instr[15:11] == HALT_OPC)) halted_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      halted_q <= halted_d;
    end
  end

  // NOTE: the data array has no reset; id_valid masks stale contents, so
  // clearing it would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{instr: if_instr, pc_next: if_pc_next};
  end

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Self-checking bench for fetch_decode_buffer: directed vector table, hand
// sequences for HALT/flush/async reset, and random traffic against a queue model.
module tb_fetch_decode_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc_next;
  logic        if_ready;
  logic        id_valid;
  logic [15:0] id_instr;
  logic [15:0] id_pc_next;
  logic        id_ready;
  logic        flush;
  logic        halted;
  logic [1:0]  count;

  int total = 0;
  int bad   = 0;

  fetch_decode_buffer dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc_next(if_pc_next),
    .if_ready(if_ready),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc_next(id_pc_next),
    .id_ready(id_ready), .flush(flush), .halted(halted), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic ev, input logic [15:0] ei,
                           input logic [15:0] ep, input logic er, input logic eh,
                           input logic [1:0] ec);
    check({tag, ".id_valid"},   {31'd0, id_valid}, {31'd0, ev});
    check({tag, ".id_instr"},   {16'd0, id_instr}, {16'd0, ei});
    check({tag, ".id_pc_next"}, {16'd0, id_pc_next}, {16'd0, ep});
    check({tag, ".if_ready"},   {31'd0, if_ready}, {31'd0, er});
    check({tag, ".halted"},     {31'd0, halted}, {31'd0, eh});
    check({tag, ".count"},      {30'd0, count}, {30'd0, ec});
  endtask

  // Drives one cycle's inputs after the falling edge; outputs settle from state.
  task automatic drive(input logic v, input logic [15:0] i, input logic [15:0] p,
                       input logic r, input logic f);
    @(negedge clk);
    if_valid = v; if_instr = i; if_pc_next = p; id_ready = r; flush = f;
    #1;
  endtask

  typedef struct {
    logic        v;
    logic [15:0] i;
    logic [15:0] p;
    logic        r;
    logic        ev;
    logic [15:0] ei;
    logic [15:0] ep;
    logic        er;
    logic [1:0]  ec;
  } vec_t;

  vec_t vecs [12];

  // Reference model: a plain queue of words plus a halted flag.
  logic [31:0] mq [$];
  logic        m_halted;

  initial begin
    rst = 1'b0; if_valid = 1'b1; if_instr = 16'h4001; if_pc_next = 16'h0002;
    id_ready = 1'b1; flush = 1'b0;

    // Reset held for two cycles with fetch offering: nothing may enter.
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      check_all("reset", 1'b0, 16'h0800, 16'h0000, 1'b1, 1'b0, 2'd0);
    end
    @(negedge clk); if_valid = 1'b0; rst = 1'b1; #1;
    check_all("reset_rel", 1'b0, 16'h0800, 16'h0000, 1'b1, 1'b0, 2'd0);

    // Streaming then backpressure; expectations are pre-edge outputs.
    vecs[0]  = '{1, 16'h4001, 16'h0002, 1, 0, 16'h0800, 16'h0000, 1, 0};
    vecs[1]  = '{1, 16'h4102, 16'h0004, 1, 1, 16'h4001, 16'h0002, 1, 1};
    vecs[2]  = '{1, 16'h4203, 16'h0006, 1, 1, 16'h4102, 16'h0004, 1, 1};
    vecs[3]  = '{0, 16'h0000, 16'h0000, 1, 1, 16'h4203, 16'h0006, 1, 1};
    vecs[4]  = '{0, 16'h0000, 16'h0000, 1, 0, 16'h0800, 16'h0000, 1, 0};
    vecs[5]  = '{1, 16'h5001, 16'h0010, 0, 0, 16'h0800, 16'h0000, 1, 0};
    vecs[6]  = '{1, 16'h5002, 16'h0012, 0, 1, 16'h5001, 16'h0010, 1, 1};
    vecs[7]  = '{1, 16'h5003, 16'h0014, 0, 1, 16'h5001, 16'h0010, 0, 2};
    vecs[8]  = '{1, 16'h5003, 16'h0014, 1, 1, 16'h5001, 16'h0010, 0, 2};
    vecs[9]  = '{1, 16'h5003, 16'h0014, 1, 1, 16'h5002, 16'h0012, 1, 1};
    vecs[10] = '{0, 16'h0000, 16'h0000, 1, 1, 16'h5003, 16'h0014, 1, 1};
    vecs[11] = '{0, 16'h0000, 16'h0000, 1, 0, 16'h0800, 16'h0000, 1, 0};
    for (int k = 0; k < 12; k++) begin
      drive(vecs[k].v, vecs[k].i, vecs[k].p, vecs[k].r, 1'b0);
      check_all($sformatf("vec%0d", k), vecs[k].ev, vecs[k].ei, vecs[k].ep,
                vecs[k].er, 1'b0, vecs[k].ec);
    end

    // HALT: fill with decode stalled, keep fetch offering afterwards.
    drive(1, 16'h1234, 16'h0100, 0, 0);
    drive(1, 16'h0000, 16'h0102, 0, 0);
    check_all("halt_one", 1'b1, 16'h1234, 16'h0100, 1'b1, 1'b0, 2'd1);
    drive(1, 16'h7777, 16'h0104, 1, 0);
    check_all("halt_set", 1'b1, 16'h1234, 16'h0100, 1'b0, 1'b1, 2'd2);
    drive(1, 16'h7777, 16'h0104, 1, 0);
    check_all("halt_drain", 1'b1, 16'h0000, 16'h0102, 1'b0, 1'b1, 2'd1);
    for (int c = 0; c < 4; c++) begin
      drive(1, 16'h7777, 16'h0104, 1, 0);
      check_all("halt_idle", 1'b0, 16'h0800, 16'h0000, 1'b0, 1'b1, 2'd0);
    end

    // Flush clears halted; refill to two and flush with offer and consume.
    drive(1, 16'h7777, 16'h0104, 1, 1);
    drive(1, 16'h2001, 16'h0200, 0, 0);
    check_all("flush_unhalt", 1'b0, 16'h0800, 16'h0000, 1'b1, 1'b0, 2'd0);
    drive(1, 16'h2002, 16'h0202, 0, 0);
    drive(1, 16'h2003, 16'h0204, 1, 1);
    check_all("flush_pre", 1'b1, 16'h2001, 16'h0200, 1'b0, 1'b0, 2'd2);
    drive(1, 16'h6001, 16'h0300, 0, 0);
    check_all("flush_post", 1'b0, 16'h0800, 16'h0000, 1'b1, 1'b0, 2'd0);
    drive(0, 16'h0000, 16'h0000, 1, 0);
    check_all("flush_next", 1'b1, 16'h6001, 16'h0300, 1'b1, 1'b0, 2'd1);

    // Asynchronous reset between edges while full.
    drive(1, 16'h3001, 16'h0400, 0, 0);
    drive(1, 16'h3002, 16'h0402, 0, 0);
    @(posedge clk); #2;
    check("async_pre.count", {30'd0, count}, 32'd2);
    rst = 1'b0; #1;
    check_all("async_rst", 1'b0, 16'h0800, 16'h0000, 1'b1, 1'b0, 2'd0);
    @(negedge clk); rst = 1'b1; if_valid = 1'b0;

    // Random traffic against the queue model.
    mq.delete(); m_halted = 1'b0;
    for (int c = 0; c < 400; c++) begin
      logic        v, r, f, mr, mpush, mpop;
      logic [15:0] ins, pc;
      v   = ($urandom_range(0, 3) != 0);
      r   = ($urandom_range(0, 2) != 0);
      f   = ($urandom_range(0, 19) == 0);
      ins = 16'($urandom);
      pc  = 16'($urandom);
      drive(v, ins, pc, r, f);
      mr = (mq.size() < 2) && !m_halted;
      if (mq.size() == 0)
        check_all($sformatf("rnd%0d", c), 1'b0, 16'h0800, 16'h0000, mr, m_halted, 2'd0);
      else
        check_all($sformatf("rnd%0d", c), 1'b1, mq[0][31:16], mq[0][15:0], mr,
                  m_halted, 2'(mq.size()));
      mpush = v && mr && !f;
      mpop  = (mq.size() != 0) && r && !f;
      if (f) begin
        mq.delete(); m_halted = 1'b0;
      end else begin
        if (mpop) void'(mq.pop_front());
        if (mpush) begin
          mq.push_back({ins, pc});
          if (ins[15:11] == 5'b00000) m_halted = 1'b1;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
